// File: rtl/benes_cfg_scheduler_if.sv
// benes_cfg_scheduler_if
//
// Configuration load channel into the Benes scheduler's shadow bank.
//   cfg_valid  : requester has a beat on the bus
//   cfg_ready  : scheduler can take a load/commit beat this cycle
//   cfg_stage  : target stage row for cfg_data
//   cfg_data   : switch word, bit i = cross for switch i of that stage
//   cfg_commit : this beat also starts the skewed apply of the shadow bank
//
// master modport is the requester side, slave modport is the scheduler side.
interface benes_cfg_scheduler_if #(
    parameter int SW_PER_STAGE = 8
);
    logic                    cfg_valid;
    logic                    cfg_ready;
    logic [2:0]              cfg_stage;
    logic [SW_PER_STAGE-1:0] cfg_data;
    logic                    cfg_commit;

    modport master (
        output cfg_valid,
        output cfg_stage,
        output cfg_data,
        output cfg_commit,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_stage,
        input  cfg_data,
        input  cfg_commit,
        output cfg_ready
    );
endinterface

// File: rtl/benes_cfg_scheduler.sv
// benes_cfg_scheduler
//
// Configuration scheduler for a pipelined 16x16 Benes network (7 stages of
// 8 2x2 switches). Switch words are loaded into a shadow bank over the cfg
// channel; a commit beat copies the shadow into the active bank as a skewed
// wavefront so that every stage flips exactly when the first post-commit
// data wave arrives there. Data-wave validity is tracked alongside.
//
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   cfg         : load channel (slave side of benes_cfg_scheduler_if)
//   in_valid    : a data wave enters the network this cycle
//   switch_set  : active per-stage switch words driven to the network
//   out_valid   : network output carries a valid wave this cycle
//   busy        : skewed apply in progress
//   cfg_err     : one-cycle pulse after an accepted beat with an
//                 out-of-range stage index
//
// Optional feature macro BENES_CFG_READBACK_EN adds rb_stage/rb_sel inputs
// and a registered rb_data output reading back the shadow (rb_sel=0) or the
// active (rb_sel=1) bank.
module benes_cfg_scheduler #(
    parameter int NUM_STAGES   = 7,
    parameter int SW_PER_STAGE = 8,
    parameter int STAGE_LAT    = 2
) (
    input  logic                                     clk,
    input  logic                                     rst,
    benes_cfg_scheduler_if.slave                     cfg,
    input  logic                                     in_valid,
    output logic [NUM_STAGES-1:0][SW_PER_STAGE-1:0]  switch_set,
    output logic                                     out_valid,
    output logic                                     busy,
`ifdef BENES_CFG_READBACK_EN
    input  logic [2:0]                               rb_stage,
    input  logic                                     rb_sel,
    output logic [SW_PER_STAGE-1:0]                  rb_data,
`endif
    output logic                                     cfg_err
);

    localparam int NET_LAT    = NUM_STAGES * STAGE_LAT - 1;
    localparam int APPLY_LAST = (NUM_STAGES - 1) * STAGE_LAT;
    localparam int CNT_W      = $clog2(APPLY_LAST + 1);

    typedef enum logic {LOAD, APPLY} state_t;

    state_t                                  state;
    logic [CNT_W-1:0]                        count;
    logic                                    ready_q;
    logic [NUM_STAGES-1:0][SW_PER_STAGE-1:0] shadow;
    logic [NUM_STAGES-1:0][SW_PER_STAGE-1:0] active;
    logic [NET_LAT-1:0]                      valid_pipe;

    logic accept;
    logic stage_ok;
    logic wr_en;

    assign accept        = cfg.cfg_valid && ready_q;
    assign stage_ok      = 32'(cfg.cfg_stage) < NUM_STAGES;
    assign wr_en         = accept && stage_ok;
    assign cfg.cfg_ready = ready_q;
    assign switch_set    = active;
    assign out_valid     = valid_pipe[NET_LAT-1];

    // Shadow bank: written only by accepted in-range beats. Ready is low for
    // the whole apply, so the rows being copied cannot change underneath it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
        end else if (wr_en) begin
            shadow[cfg.cfg_stage] <= cfg.cfg_data;
        end
    end

    // Apply FSM. Stage 0 is loaded on the commit edge itself (forwarding the
    // commit beat's own write), and stage k is loaded on the edge where the
    // count reaches k*STAGE_LAT, so stage k changes in the same cycle the
    // first post-commit wave enters it. The FSM returns to LOAD once the last
    // stage has been visible for its first cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= LOAD;
            count   <= '0;
            ready_q <= 1'b1;
            busy    <= 1'b0;
            active  <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept && cfg.cfg_commit) begin
                        state   <= APPLY;
                        count   <= '0;
                        ready_q <= 1'b0;
                        busy    <= 1'b1;
                        if (wr_en && cfg.cfg_stage == 3'd0) begin
                            active[0] <= cfg.cfg_data;
                        end else begin
                            active[0] <= shadow[0];
                        end
                    end
                end
                APPLY: begin
                    for (int k = 1; k < NUM_STAGES; k++) begin
                        if (32'(count) + 1 == k * STAGE_LAT) begin
                            active[k] <= shadow[k];
                        end
                    end
                    if (32'(count) == APPLY_LAST) begin
                        state   <= LOAD;
                        count   <= '0;
                        ready_q <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    state   <= LOAD;
                    ready_q <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Error pulse: one cycle after any accepted beat whose stage index has no
    // matching row. The write itself is dropped by wr_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= accept && !stage_ok;
        end
    end

    // Validity shadow of the data path: in_valid delayed by the network
    // latency, running regardless of the apply state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_pipe <= '0;
        end else begin
            valid_pipe <= {valid_pipe[NET_LAT-2:0], in_valid};
        end
    end

`ifdef BENES_CFG_READBACK_EN
    // Registered readback of either bank; rows that do not exist read as 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rb_data <= '0;
        end else if (32'(rb_stage) >= NUM_STAGES) begin
            rb_data <= '0;
        end else if (rb_sel) begin
            rb_data <= active[rb_stage];
        end else begin
            rb_data <= shadow[rb_stage];
        end
    end
`endif

endmodule

// File: doc/benes_cfg_scheduler.md
Name: benes_cfg_scheduler

Overview:
- Configuration scheduler for the 7-stage, 16x16 pipelined Benes permutation network.
- Accepts per-stage switch words through a valid/ready load interface into a shadow bank.
- On commit, applies the words to the network's active switch_set outputs as a skewed wavefront, so each stage changes exactly when the first post-commit data wave reaches it.
- Also tracks data-wave validity through the network latency.

Parameters:
- NUM_STAGES, 7, number of switch stages (switch_set rows).
- SW_PER_STAGE, 8, 2x2 switches per stage (bits per switch_set word).
- STAGE_LAT, 2, cycles between a data wave entering stage k and entering stage k+1.
- NET_LAT, NUM_STAGES*STAGE_LAT-1 (13), cycles from i_port sample to o_port valid; derived, not overridden.

Ports:
- clk, input, 1, sole clock; all state on rising edge.
- rst, input, 1, asynchronous, active-high reset.
- cfg_valid, input, 1, load request.
- cfg_ready, output, 1, scheduler can accept a load/commit.
- cfg_stage, input, 3, target stage index for cfg_data.
- cfg_data, input, SW_PER_STAGE, switch word (bit i = cross for switch i).
- cfg_commit, input, 1, qualifies the beat as a commit; commit beats also write cfg_data.
- in_valid, input, 1, a data wave is presented on the network i_port this cycle.
- switch_set, output, NUM_STAGES x SW_PER_STAGE, active per-stage switch words to the network.
- out_valid, output, 1, network o_port carries a valid wave this cycle.
- busy, output, 1, skewed apply in progress.
- cfg_err, output, 1, one-cycle pulse when an accepted beat had cfg_stage >= NUM_STAGES.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - shadow and active banks = 0 (all bar/straight); switch_set = 0.
  - FSM = LOAD; cfg_ready = 1; busy = 0; out_valid = 0; cfg_err = 0.
  - Valid pipeline cleared.
- Handshake:
  - A beat is accepted when cfg_valid && cfg_ready.
  - Accepted beat with cfg_stage < NUM_STAGES writes shadow[cfg_stage] = cfg_data.
  - Accepted beat with cfg_stage >= NUM_STAGES drops the write and raises cfg_err next cycle, for one cycle.
  - Unwritten shadow rows keep their previous values; partial reconfiguration is legal.
- FSM LOAD:
  - cfg_ready = 1.
  - An accepted beat with cfg_commit = 1 (write applied first, even an erroring write is ignored) -> APPLY, count = 0.
- FSM APPLY:
  - cfg_ready = 0; busy = 1.
  - count increments each cycle.
  - When count == k*STAGE_LAT, active[k] <= shadow[k].
  - With commit accepted at cycle t, stage k's new word is visible on switch_set from cycle t+1+k*STAGE_LAT.
  - After active[NUM_STAGES-1] is loaded (count == (NUM_STAGES-1)*STAGE_LAT) -> LOAD; busy falls the following cycle.
  - APPLY lasts 13 cycles with defaults.
- Wavefront rule:
  - A wave with in_valid at cycle <= t traverses entirely on the old configuration.
  - A wave with in_valid at cycle >= t+1 traverses entirely on the new one.
  - The network is never stalled.
- Valid tracking: out_valid = in_valid delayed NET_LAT cycles through a shift register; independent of FSM state.
- cfg_valid while cfg_ready = 0 is not accepted; the requester holds the beat.
- Shadow writes are impossible during APPLY (ready low), so the shadow is stable while copied.
- Reset mid-APPLY: active returns to 0 immediately (async); partially applied wavefront is discarded.
- Width: count sized clog2((NUM_STAGES-1)*STAGE_LAT+1); no wrap occurs inside APPLY.

Optional Feature:
- Macro BENES_CFG_READBACK_EN.
- Defined:
  - Adds input rb_stage (3 bits), input rb_sel (1 bit), output rb_data (SW_PER_STAGE bits).
  - rb_data is registered, 1-cycle latency: shadow[rb_stage] when rb_sel = 0, active[rb_stage] when rb_sel = 1.
  - Out-of-range rb_stage returns 0. rb_data resets to 0.
- Undefined: ports absent; no readback logic.

Test Plan:
- Reset, then idle 5 cycles -> switch_set all 0, cfg_ready = 1, busy = 0, out_valid = 0, cfg_err = 0.
- Write stages 0..6 with 0x11*k+1, commit on stage-6 beat at cycle t:
  - switch_set[0] = 0x01 at t+1 and switch_set[6] = 0x67 at t+13.
  - No other stage changes early; busy high t+1..t+13.
- During APPLY hold cfg_valid=1 (stage 2, 0xFF) -> not accepted until cfg_ready returns; applying afterwards with commit changes only stage 2 to 0xFF.
- in_valid single pulse at cycle c -> out_valid single pulse at c+13; back-to-back in_valid for 4 cycles -> 4-cycle out_valid burst.
- Beat with cfg_stage = 7, cfg_data = 0xAA -> cfg_err pulses 1 cycle, shadow unchanged; with commit set, APPLY re-applies the existing shadow.
- Assert rst at count = 5 of APPLY -> switch_set all 0 immediately, FSM LOAD, cfg_ready = 1 after deassert.
